// File: rtl/aes256_inv_key_schedule.sv
// AES-256 inverse key schedule: expands forward to K13/K14, then emits K14..K0 over a valid/ready port.
// Optional build macro AES_INV_KEY_CACHE_EN keeps the last K13/K14 pair so that a repeated key skips the forward pass.
module aes256_inv_key_schedule #(
  parameter bit ZEROIZE_ON_DONE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] short_key,
  output logic [127:0] subkey,
  output logic         subkey_valid,
  input  logic         subkey_ready,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  // Handshake: a round key transfers on a rising edge where subkey_valid && subkey_ready.
  // While valid && !ready, subkey and round_idx hold. Ready has no effect while valid is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_REV  = 2'd2
  } state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // The field inverse is computed as x^254, which maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   hi_q, hi_d;
  logic [127:0]   lo_q, lo_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     round_idx_q, round_idx_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

`ifdef AES_INV_KEY_CACHE_EN
  logic [255:0]   tag_q, tag_d;
  logic [127:0]   k13_q, k13_d;
  logic [127:0]   k14_q, k14_d;
  logic           cache_vld_q, cache_vld_d;
`endif

  // Both directions apply t() to lo.w3, so one SubWord unit serves FWD and REV.
  logic           rot_sel;
  logic [2:0]     rcon_idx;
  logic [31:0]    t_in;
  logic [31:0]    t_word;
  logic [31:0]    h0, h1, h2, h3;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;
  logic [127:0]   prev_key;

  always_comb begin
    rot_sel  = 1'b0;
    rcon_idx = 3'd0;
    if (state_q == S_FWD) begin
      rot_sel  = ~cnt_q[0];
      rcon_idx = cnt_q[3:1] + 3'd1;
    end else begin
      rot_sel  = ~round_idx_q[0];
      rcon_idx = round_idx_q[3:1];
    end
    t_in   = rot_sel ? {lo_q[23:0], lo_q[31:24]} : lo_q[31:0];
    t_word = sub_word(t_in) ^ {(rot_sel ? rcon(rcon_idx) : 8'h00), 24'h000000};
  end

  // Forward words chain within a step; backward words depend only on hi and t.
  always_comb begin
    h0 = hi_q[127:96];
    h1 = hi_q[95:64];
    h2 = hi_q[63:32];
    h3 = hi_q[31:0];
    n0 = h0 ^ t_word;
    n1 = h1 ^ n0;
    n2 = h2 ^ n1;
    n3 = h3 ^ n2;
    next_key = {n0, n1, n2, n3};
    prev_key = {h0 ^ t_word, h1 ^ h0, h2 ^ h1, h3 ^ h2};
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    round_idx_d = round_idx_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
    tag_d       = tag_q;
    k13_d       = k13_q;
    k14_d       = k14_q;
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
`ifdef AES_INV_KEY_CACHE_EN
          if (cache_vld_q && (short_key == tag_q)) begin
            hi_d        = k14_q;
            lo_d        = k13_q;
            round_idx_d = 4'd14;
            state_d     = S_REV;
          end else begin
            hi_d        = short_key[255:128];
            lo_d        = short_key[127:0];
            cnt_d       = 4'd0;
            state_d     = S_FWD;
            tag_d       = short_key;
            cache_vld_d = 1'b0;
          end
`else
          hi_d    = short_key[255:128];
          lo_d    = short_key[127:0];
          cnt_d   = 4'd0;
          state_d = S_FWD;
`endif
        end
      end
      S_FWD: begin
        if (cnt_q == 4'd13) begin
          hi_d        = lo_q;
          lo_d        = hi_q;
          round_idx_d = 4'd14;
          valid_d     = 1'b1;
          state_d     = S_REV;
`ifdef AES_INV_KEY_CACHE_EN
          k13_d       = hi_q;
          k14_d       = lo_q;
          cache_vld_d = 1'b1;
`endif
        end else begin
          hi_d  = lo_q;
          lo_d  = next_key;
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_REV: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (subkey_ready) begin
          if (round_idx_q == 4'd0) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (ZEROIZE_ON_DONE) begin
              hi_d = '0;
              lo_d = '0;
            end
          end else begin
            hi_d        = lo_q;
            lo_d        = prev_key;
            round_idx_d = round_idx_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= 4'd0;
      round_idx_q <= 4'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      round_idx_q <= round_idx_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef AES_INV_KEY_CACHE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q       <= '0;
      k13_q       <= '0;
      k14_q       <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      k13_q       <= k13_d;
      k14_q       <= k14_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`endif

  assign subkey       = hi_q;
  assign subkey_valid = valid_q;
  assign round_idx    = round_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
